// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state type and nibble constants for the serial adder
package serial_add_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction
endpackage

// File: rtl/adder4_slice.sv
// adder4_slice: 4-bit add with carry-in, exposing carry-out and the carry into the top bit
module adder4_slice
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);
  assign {c3, sum[NIBBLE_W-2:0]} = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]} + NIBBLE_W'(cin);
  assign {cout, sum[NIBBLE_W-1]} = {1'b0, a[NIBBLE_W-1]} + {1'b0, b[NIBBLE_W-1]} + {1'b0, c3};
endmodule

// File: rtl/serial_add_controller.sv
// serial_add_controller: nibble-serial adder, one shared 4-bit slice; SERIAL_ADD_SUB_EN adds a subtract port
module serial_add_controller
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             subtract,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);
  localparam int N = nibble_count(WIDTH);
  localparam int IW = $clog2(N);
  state_t state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic carry, sub_op, last;
  logic [NIBBLE_W-1:0] s_nib;
  logic s_co, s_c3;
`ifdef SERIAL_ADD_SUB_EN
  assign sub_op = subtract;
`else
  assign sub_op = 1'b0;
`endif
  assign last = idx == IW'(N - 1);
  adder4_slice u_slice (
    .a   (a_q[NIBBLE_W*idx +: NIBBLE_W]),
    .b   (b_q[NIBBLE_W*idx +: NIBBLE_W]),
    .cin (carry),
    .sum (s_nib),
    .cout(s_co),
    .c3  (s_c3)
  );
  // control FSM: capture on start, one nibble per RUN edge, one-cycle done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          a_q   <= a;
          b_q   <= sub_op ? ~b : b;
          carry <= sub_op;
          idx   <= '0;
        end
        RUN: begin
          sum[NIBBLE_W*idx +: NIBBLE_W] <= s_nib;
          carry <= s_co;
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            carryout <= s_co;
            overflow <= s_co ^ s_c3;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
